// File: rtl/sc_fifo.sv
// Single-clock FIFO over an inferred RAM with word count, almost flags and
// show-ahead/normal read modes. Sticky overflow/underflow flags: SC_FIFO_ERR_FLAGS_EN.
module sc_fifo #(
  parameter int unsigned DWIDTH           = 8,
  parameter int unsigned AWIDTH           = 3,
  parameter string       SHOWAHEAD        = "OFF",
  parameter int unsigned ALMOST_FULL_LVL  = 2**AWIDTH - 2,
  parameter int unsigned ALMOST_EMPTY_LVL = 2
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              wr_req_i,
  input  logic              rd_req_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              almost_full_o,
  output logic              almost_empty_o
`ifdef SC_FIFO_ERR_FLAGS_EN
  ,
  output logic              overflow_o,
  output logic              underflow_o
`endif
);

  localparam int unsigned     DEPTH     = 2**AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_CNT = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_LVL    = (AWIDTH+1)'(ALMOST_FULL_LVL);
  localparam logic [AWIDTH:0] AE_LVL    = (AWIDTH+1)'(ALMOST_EMPTY_LVL);
  localparam bit              SHOW      = (SHOWAHEAD == "ON");

  logic [DWIDTH-1:0] mem [DEPTH];

  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [AWIDTH-1:0] rd_ptr_next;
  logic [AWIDTH-1:0] rd_addr;
  logic [AWIDTH:0]   usedw;
  logic [AWIDTH:0]   usedw_next;
  logic              full;
  logic              empty;
  logic              wr_en;
  logic              rd_en;
  logic              q_load;
  logic              bypass;
  logic [DWIDTH-1:0] q;
  logic [DWIDTH-1:0] rd_word;

  always_comb begin
    wr_en       = wr_req_i && !full;
    rd_en       = rd_req_i && !empty;
    rd_ptr_next = rd_en ? rd_ptr + AWIDTH'(1) : rd_ptr;
    usedw_next  = usedw;
    case ({wr_en, rd_en})
      2'b10:   usedw_next = usedw + (AWIDTH+1)'(1);
      2'b01:   usedw_next = usedw - (AWIDTH+1)'(1);
      default: usedw_next = usedw;
    endcase
  end

  // Show-ahead reads the RAM at the post-pop address so the new head lands on
  // the next edge; a word written on that same edge is forwarded from data_i.
  // An empty FIFO or a pop down to empty leaves q holding its last value.
  always_comb begin
    rd_addr = rd_ptr;
    bypass  = 1'b0;
    q_load  = rd_en;
    if (SHOW) begin
      rd_addr = rd_ptr_next;
      bypass  = wr_en && (wr_ptr == rd_ptr_next);
      q_load  = !empty && (usedw_next != '0);
    end
    rd_word = bypass ? data_i : mem[rd_addr];
  end

  always_ff @(posedge clk_i) begin
    if (srst_i && wr_en) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usedw  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      q      <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AWIDTH'(1);
      end
      rd_ptr <= rd_ptr_next;
      usedw  <= usedw_next;
      full   <= (usedw_next == DEPTH_CNT);
      empty  <= (usedw_next == '0);
      if (q_load) begin
        q <= rd_word;
      end
    end
  end

`ifdef SC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (wr_req_i && full) begin
        overflow_o <= 1'b1;
      end
      if (rd_req_i && empty) begin
        underflow_o <= 1'b1;
      end
    end
  end
`endif

  assign q_o            = q;
  assign empty_o        = empty;
  assign full_o         = full;
  assign usedw_o        = usedw;
  assign almost_full_o  = (usedw >= AF_LVL);
  assign almost_empty_o = (usedw < AE_LVL);

endmodule

// File: doc/sc_fifo.md
# sc_fifo

Single-clock, parametrised FIFO built around an inferred M10K RAM: the single-clock successor to the team's dual-clock FIFO storage. Adds a full pointer/flag controller, a word counter, programmable almost-full/almost-empty thresholds and a selectable show-ahead or normal read mode. Sits between a producer and consumer in the same clock domain, e.g. packet buffering in the lab datapath.

## Interface
- `DWIDTH`, 8, data word width in bits.
- `AWIDTH`, 3, address width; depth = 2**AWIDTH words.
- `SHOWAHEAD`, "OFF", "ON" = head word presented on `q_o` without a request; "OFF" = word appears after `rd_req_i`.
- `ALMOST_FULL_LVL`, 2**AWIDTH-2, `almost_full_o` threshold, 1..2**AWIDTH.
- `ALMOST_EMPTY_LVL`, 2, `almost_empty_o` threshold, 1..2**AWIDTH.
- `clk_i`  in  1  single clock; all logic on rising edge.
- `srst_i`  in  1  synchronous reset, active-low.
- `data_i`  in  DWIDTH  write data.
- `wr_req_i`  in  1  write request.
- `rd_req_i`  in  1  read request; acknowledge in show-ahead mode.
- `q_o`  out  DWIDTH  read data.
- `empty_o`  out  1  FIFO holds 0 words.
- `full_o`  out  1  FIFO holds 2**AWIDTH words.
- `usedw_o`  out  AWIDTH+1  stored word count, 0..2**AWIDTH.
- `almost_full_o`  out  1  `usedw_o >= ALMOST_FULL_LVL`.
- `almost_empty_o`  out  1  `usedw_o < ALMOST_EMPTY_LVL`.
- `overflow_o`, `underflow_o`  out  1 each  sticky error flags; present only with `SC_FIFO_ERR_FLAGS_EN`.

## Operation
- Storage: 2**AWIDTH x DWIDTH RAM. Write pointer and read pointer are each AWIDTH bits and wrap naturally from 2**AWIDTH-1 to 0.
- Write accepted iff `wr_req_i && !full_o`: write `data_i` at the write pointer, then increment the write pointer.
- Read accepted iff `rd_req_i && !empty_o`: increment the read pointer.
- `usedw_o`:
  - +1 on an accepted write only.
  - −1 on an accepted read only.
  - Unchanged when both or neither are accepted.
- `full_o` and `empty_o` are registered and updated in the same edge as `usedw_o`.
- `full_o` = (next usedw == 2**AWIDTH).
- `empty_o` = (next usedw == 0).
- Simultaneous requests:
  - When full, the read is accepted and the write is dropped.
  - When empty, the write is accepted and the read is ignored.
  - Otherwise both are accepted and the count is unchanged.
- Requests that are not accepted change no state. They are not an error unless `SC_FIFO_ERR_FLAGS_EN` is defined.
- `SHOWAHEAD="OFF"`: `q_o` loads the RAM word at the read pointer on an accepted read and holds otherwise.
- `SHOWAHEAD="ON"`: whenever `!empty_o`, `q_o` shows the head word. `rd_req_i` pops it, and the next word (if any) appears on the following cycle. While `empty_o`, `q_o` holds its last value.
- Almost flags are combinational compares of registered `usedw_o`. They have no extra latency.
- Reset (`srst_i`=0 at an edge):
  - Pointers 0, `usedw_o`=0, `empty_o`=1, `full_o`=0.
  - `almost_empty_o`=1, `almost_full_o`=0, `q_o`=0, error flags 0.
  - RAM contents are not cleared.
  - Reset wins over any request in the same cycle. A reset mid-operation discards all stored words.

## Timing
- Write to `usedw_o`/`empty_o` update: 1 cycle.
- Write into an empty FIFO to data visible on `q_o` in show-ahead mode: 2 cycles, i.e. valid the cycle after `empty_o` falls. This covers the registered RAM read. The implementation must produce this using read-pointer-next addressing plus write-through bypass.
- Normal mode: `q_o` valid 1 cycle after an accepted read.
- Throughput: one write and one read per cycle, sustained indefinitely at any fill level except the full/empty boundary rules above.
- No read-during-write hazard may be visible: a word is readable only once it has been counted in `usedw_o`.

## Configuration
- `SC_FIFO_ERR_FLAGS_EN` defined:
  - `overflow_o` sets on `wr_req_i && full_o`.
  - `underflow_o` sets on `rd_req_i && empty_o`.
  - Both are sticky until reset.
- Not defined: ports `overflow_o`/`underflow_o` and their logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset then idle (DWIDTH=8, AWIDTH=3):
  - Required: `empty_o`=1, `full_o`=0, `usedw_o`=0, `almost_empty_o`=1, `q_o`=0.
- Write 0x01..0x08 on consecutive cycles:
  - `usedw_o` counts 1..8.
  - `full_o`=1 after the 8th write and `almost_full_o`=1 from usedw=6.
  - A 9th write (0xFF) is dropped; `overflow_o`=1 when `SC_FIFO_ERR_FLAGS_EN` is defined.
- Read 8 words, normal mode:
  - `q_o` = 0x01..0x08, each 1 cycle after its request.
  - `empty_o`=1 after the last read.
  - An extra read leaves `q_o`=0x08 and `usedw_o`=0.
- Show-ahead mode: write 0xA5 into an empty FIFO:
  - `empty_o` falls 1 cycle later and `q_o`=0xA5 the next cycle, with no `rd_req_i`.
  - Popping it returns `empty_o`=1.
- Simultaneous requests:
  - At usedw=4 for 20 cycles: `usedw_o` stays 4 and data order is preserved across pointer wrap.
  - When full: the read is accepted, the write is dropped, `usedw_o`=7.
  - When empty: the write is accepted, `usedw_o`=1.
- Reset asserted at usedw=5:
  - Next cycle `usedw_o`=0 and `empty_o`=1.
  - A following write/read returns the new data, not stale data.
